carrega_8_num: RTL and testbench

CARREGA_8_NUM -- requirements
Module: carrega_8_num

---
 rtl/carrega_8_num_pkg.sv | 20 ++
 rtl/carrega_8_num.sv | 112 +++++++++++
 tb/tb_carrega_8_num.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/carrega_8_num_pkg.sv
// Shared constants and types for the 8-number frame loader.
// Pad values are chosen so that padded slots sort after every real word.
package carrega_pkg;

  localparam int LARGURA_PADRAO = 8;
  localparam int N_NUM          = 8;

  typedef enum logic {
    COLETA = 1'b0,
    CHEIO  = 1'b1
  } estado_t;

  localparam logic [7:0] PAD_CRESC  = 8'hFF;
  localparam logic [7:0] PAD_DECRES = 8'h00;

  function automatic logic [7:0] pad_valor(input logic cresc);
    return cresc ? PAD_CRESC : PAD_DECRES;
  endfunction

endpackage

// File: rtl/carrega_8_num.sv
// Collects up to eight words into a frame and presents it to the sorter until released.
// Optional early flush with sort-aware padding is enabled by CARREGA_8_NUM_FLUSH_EN.
module carrega_8_num
  import carrega_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [LARGURA-1:0] in_data,
  output logic               in_ready,
  input  logic               cresc_in,
  input  logic               libera,
`ifdef CARREGA_8_NUM_FLUSH_EN
  input  logic               flush,
`endif
  output logic               ena,
  output logic               cresc_ou_decres,
  output logic [LARGURA-1:0] n1_n,
  output logic [LARGURA-1:0] n2_n,
  output logic [LARGURA-1:0] n3_n,
  output logic [LARGURA-1:0] n4_n,
  output logic [LARGURA-1:0] n5_n,
  output logic [LARGURA-1:0] n6_n,
  output logic [LARGURA-1:0] n7_n,
  output logic [LARGURA-1:0] n8_n,
  output logic [3:0]         qtd
);

  estado_t            state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [3:0]         qtd_q, qtd_d;
  logic               cresc_q, cresc_d;
  logic               rdy_q;
  logic [LARGURA-1:0] slot_q [N_NUM];
  logic [LARGURA-1:0] slot_d [N_NUM];
  logic               aceita;

  // rdy_q keeps in_ready low while reset is held and for the edge it is released on.
  assign in_ready = rdy_q && (state_q == COLETA);
  assign aceita   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    qtd_d   = qtd_q;
    cresc_d = cresc_q;
    slot_d  = slot_q;
    case (state_q)
      COLETA: begin
        if (aceita) begin
          slot_d[ptr_q] = in_data;
          if (ptr_q == 3'd0) cresc_d = cresc_in;
          ptr_d = ptr_q + 3'd1;
          qtd_d = qtd_q + 4'd1;
          if (ptr_q == 3'd7) state_d = CHEIO;
        end
`ifdef CARREGA_8_NUM_FLUSH_EN
        // A word accepted on the flush edge lands first; padding begins right after it.
        if (flush && (qtd_q != 4'd0)) begin
          for (int i = 0; i < N_NUM; i++) begin
            if (4'(i) >= ({1'b0, ptr_q} + {3'b000, aceita}))
              slot_d[i] = LARGURA'(pad_valor(cresc_q));
          end
          state_d = CHEIO;
          ptr_d   = 3'd0;
        end
`endif
      end
      CHEIO: begin
        if (libera) begin
          state_d = COLETA;
          qtd_d   = 4'd0;
          ptr_d   = 3'd0;
        end
      end
      default: state_d = COLETA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLETA;
      ptr_q   <= 3'd0;
      qtd_q   <= 4'd0;
      cresc_q <= 1'b1;
      rdy_q   <= 1'b0;
      for (int i = 0; i < N_NUM; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      qtd_q   <= qtd_d;
      cresc_q <= cresc_d;
      rdy_q   <= 1'b1;
      for (int i = 0; i < N_NUM; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign ena             = (state_q == CHEIO);
  assign qtd             = qtd_q;
  assign cresc_ou_decres = cresc_q;
  assign n1_n = slot_q[0];
  assign n2_n = slot_q[1];
  assign n3_n = slot_q[2];
  assign n4_n = slot_q[3];
  assign n5_n = slot_q[4];
  assign n6_n = slot_q[5];
  assign n7_n = slot_q[6];
  assign n8_n = slot_q[7];

endmodule

// File: tb/tb_carrega_8_num.sv
// Self-checking bench for carrega_8_num: frame-level model compared every cycle plus literal checks.
// Flush scenarios run only when CARREGA_8_NUM_FLUSH_EN is defined.
module tb_carrega_8_num;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       cresc_in = 1'b0;
  logic       libera = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready, ena, cresc_ou_decres;
  logic [7:0] n1_n, n2_n, n3_n, n4_n, n5_n, n6_n, n7_n, n8_n;
  logic [3:0] qtd;
  logic [7:0] nout [8];

  int n_tests = 0;
  int n_fail  = 0;

  carrega_8_num #(.LARGURA(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cresc_in(cresc_in), .libera(libera),
`ifdef CARREGA_8_NUM_FLUSH_EN
    .flush(flush),
`endif
    .ena(ena), .cresc_ou_decres(cresc_ou_decres),
    .n1_n(n1_n), .n2_n(n2_n), .n3_n(n3_n), .n4_n(n4_n),
    .n5_n(n5_n), .n6_n(n6_n), .n7_n(n7_n), .n8_n(n8_n), .qtd(qtd)
  );

  assign nout[0] = n1_n;
  assign nout[1] = n2_n;
  assign nout[2] = n3_n;
  assign nout[3] = n4_n;
  assign nout[4] = n5_n;
  assign nout[5] = n6_n;
  assign nout[6] = n7_n;
  assign nout[7] = n8_n;

  always #5 clk = ~clk;

  // Frame model: a count of stored words plus a "frame presented" flag.
  typedef struct packed {
    logic [7:0][7:0] slot;
    logic [3:0]      cnt;
    logic            full;
    logic            order;
    logic            started;
  } mdl_t;

  localparam mdl_t MDL_RST = '{slot: '0, cnt: 4'd0, full: 1'b0, order: 1'b1, started: 1'b0};
  mdl_t m = MDL_RST;

  function automatic mdl_t step(mdl_t s, logic v, logic [7:0] d, logic c, logic lib, logic fl);
    mdl_t r = s;
    if (!s.full) begin
      if (v && s.started) begin
        if (s.cnt == 4'd0) r.order = c;
        r.slot[s.cnt[2:0]] = d;
        r.cnt = s.cnt + 4'd1;
        if (r.cnt == 4'd8) r.full = 1'b1;
      end
      if (fl && s.cnt != 4'd0) begin
        for (int k = 0; k < 8; k++)
          if (k >= int'(r.cnt)) r.slot[k] = r.order ? 8'hFF : 8'h00;
        r.full = 1'b1;
      end
    end else if (lib) begin
      r.full = 1'b0;
      r.cnt  = 4'd0;
    end
    r.started = 1'b1;
    return r;
  endfunction

  logic fl_eff;
`ifdef CARREGA_8_NUM_FLUSH_EN
  assign fl_eff = flush;
`else
  assign fl_eff = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= MDL_RST;
    else        m <= step(m, in_valid, in_data, cresc_in, libera, fl_eff);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ena", 32'(ena), 32'(m.full));
    chk("in_ready", 32'(in_ready), 32'(m.started && !m.full));
    chk("qtd", 32'(qtd), 32'(m.cnt));
    chk("cresc", 32'(cresc_ou_decres), 32'(m.order));
    for (int k = 0; k < 8; k++) chk($sformatf("slot%0d", k + 1), 32'(nout[k]), 32'(m.slot[k]));
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    int  t = 0;
    bit  acc = 1'b0;
    in_valid = 1'b1; in_data = d; cresc_in = c;
    do begin
      acc = in_ready;
      @(posedge clk); #2;
      t++;
    end while (!acc && t < 50);
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: word %0h not accepted", d);
    end
    in_valid = 1'b0;
    $display("[TB] word %02h accepted", d);
  endtask

  task automatic release_frame();
    libera = 1'b1; tick(1); libera = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] w [8], input int q, input logic c);
    chk({tag, "_ena"}, 32'(ena), 32'd1);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
    chk({tag, "_qtd"}, 32'(qtd), 32'(q));
    chk({tag, "_cresc"}, 32'(cresc_ou_decres), 32'(c));
    for (int k = 0; k < 8; k++) chk($sformatf("%s_n%0d", tag, k + 1), 32'(nout[k]), 32'(w[k]));
    $display("[TB] frame %s checked", tag);
  endtask

  logic [7:0] f1 [8] = '{8'h05, 8'h01, 8'h07, 8'h03, 8'h08, 8'h02, 8'h06, 8'h04};
  logic [7:0] f2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] f3 [8] = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h40, 8'hC0};

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ena", 32'(ena), 32'd0);
    chk("rst_qtd", 32'(qtd), 32'd0);
    chk("rst_cresc", 32'(cresc_ou_decres), 32'd1);
    chk("rst_n1", 32'(n1_n), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rel_rdy", 32'(in_ready), 32'd1);
    chk("rel_ena", 32'(ena), 32'd0);

    for (int i = 0; i < 8; i++) send(f1[i], i == 0);
    chk_frame("full", f1, 8, 1'b1);

    in_valid = 1'b1; in_data = 8'hAA;
    tick(5);
    in_valid = 1'b0;
    chk_frame("hold", f1, 8, 1'b1);
    release_frame();
    chk("lib_ena", 32'(ena), 32'd0);
    chk("lib_rdy", 32'(in_ready), 32'd1);
    chk("lib_qtd", 32'(qtd), 32'd0);
    chk("lib_n1_stale", 32'(n1_n), 32'h05);

    libera = 1'b1; tick(1); libera = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick($urandom_range(0, 2));
      send(f2[i], i != 0);
    end
    chk_frame("gaps", f2, 8, 1'b0);
    release_frame();

    for (int i = 0; i < 4; i++) send(8'h9A + 8'(i), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_qtd", 32'(qtd), 32'd0);
    chk("midrst_ena", 32'(ena), 32'd0);
    chk("midrst_n1", 32'(n1_n), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) send(f3[i], 1'b1);
    chk_frame("fresh", f3, 8, 1'b1);
    release_frame();

`ifdef CARREGA_8_NUM_FLUSH_EN
    begin
      logic [7:0] fa [8] = '{8'h30, 8'h10, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      logic [7:0] fd [8] = '{8'h30, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      flush = 1'b1; tick(1); flush = 1'b0;
      chk("flush_empty_ena", 32'(ena), 32'd0);
      for (int i = 0; i < 3; i++) send(fa[i], 1'b1);
      flush = 1'b1; tick(1); flush = 1'b0;
      chk_frame("flush_asc", fa, 3, 1'b1);
      release_frame();
      for (int i = 0; i < 3; i++) send(fd[i], 1'b0);
      flush = 1'b1; tick(1); flush = 1'b0;
      chk_frame("flush_desc", fd, 3, 1'b0);
      release_frame();
    end
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
